// File: rtl/pc.sv
// Program counter: holds the instruction address driven to instruction memory.
// Each rising edge it loads a qualified jump target, increments, or holds.
module pc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6   // must not exceed DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IPC,
    input  logic              IMPC,
    input  logic              IJ,
    input  logic [DATA_W-1:0] Din,
    output logic [ADDR_W-1:0] Dout
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Only the low ADDR_W bits of the bus form a jump target; the rest are dropped.
    generate
        if (DATA_W > ADDR_W) begin : g_trunc
            logic unused_din_hi;
            assign unused_din_hi = ^Din[DATA_W-1:ADDR_W];
        end
    endgenerate

    // Next-state: a qualified load beats increment, so a jump lands exactly on the target.
    always_comb begin
        pc_d = pc_q;
        if (IMPC && IJ) begin
            pc_d = Din[ADDR_W-1:0];
        end else if (IPC) begin
            pc_d = pc_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        end
    end

    // PC register; reset clears it immediately and discards any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Address goes out straight from the register, with no logic after it.
    assign Dout = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: a reference model plus directed vectors.
module tb_pc;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              IPC;
    logic              IMPC;
    logic              IJ;
    logic [DATA_W-1:0] Din;
    logic [ADDR_W-1:0] Dout;

    int errors   = 0;
    int n_checks = 0;
    int model    = 0;
    bit en       = 1'b0;

    pc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .IPC  (IPC),
        .IMPC (IMPC),
        .IJ   (IJ),
        .Din  (Din),
        .Dout (Dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the address a CPU should see, from the rules in plain arithmetic.
    always @(posedge clk or posedge rst) begin
        if (rst)                   model = 0;
        else if (IMPC == 1'b1 && IJ == 1'b1) model = int'(Din) % (1 << ADDR_W);
        else if (IPC == 1'b1)      model = (model + 1) % (1 << ADDR_W);
    end

    // Every falling edge once reset has been seen, Dout must match the model.
    always @(negedge clk) begin
        if (en) check("cycle", int'(Dout), model);
    end

    task automatic drive(input logic ipc, input logic impc, input logic ij, input logic [7:0] din);
        IPC = ipc; IMPC = impc; IJ = ij; Din = din;
    endtask

    // Let one rising edge happen, then check Dout shortly after it.
    task automatic edge_chk(input string name, input int exp);
        @(posedge clk);
        #2;
        check(name, int'(Dout), exp);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 8'h00);
        #3 rst = 1'b0;
        check("reset_init", int'(Dout), 8'h00);
        en = 1'b1;

        // Reach 0x2A, then async reset with no clock edge
        drive(0, 1, 1, 8'h2A);
        edge_chk("load_2A", 8'h2A);
        rst = 1'b1;
        #1 check("async_reset", int'(Dout), 8'h00);
        drive(1, 0, 0, 8'h00);
        edge_chk("rst_hold1", 8'h00);
        edge_chk("rst_hold2", 8'h00);
        rst = 1'b0;

        // Increment then hold
        edge_chk("inc1", 8'h01);
        edge_chk("inc2", 8'h02);
        edge_chk("inc3", 8'h03);
        drive(0, 0, 0, 8'h00);
        edge_chk("hold1", 8'h03);
        edge_chk("hold2", 8'h03);

        // Unqualified IMPC: increments, then holds
        drive(1, 1, 0, 8'h11);
        edge_chk("impc_noij_inc", 8'h04);
        drive(0, 1, 0, 8'h11);
        edge_chk("impc_noij_hold", 8'h04);
        // IJ alone does nothing
        drive(0, 0, 1, 8'h2B);
        edge_chk("ij_only_hold", 8'h04);

        // Load beats increment, then normal increment from target
        drive(1, 1, 1, 8'h15);
        edge_chk("load_prio", 8'h15);
        drive(1, 0, 0, 8'h00);
        edge_chk("inc_after_load", 8'h16);

        // Truncation and wrap
        drive(0, 1, 1, 8'hFF);
        edge_chk("load_FF_trunc", 8'h3F);
        drive(1, 0, 0, 8'h00);
        edge_chk("wrap", 8'h00);
        drive(0, 1, 1, 8'hE0);
        edge_chk("load_E0_trunc", 8'h20);

        // Reset during a pending jump
        drive(0, 1, 1, 8'h10);
        rst = 1'b1;
        #1 check("mid_reset", int'(Dout), 8'h00);
        #1 rst = 1'b0;
        drive(1, 0, 0, 8'h00);
        edge_chk("inc_after_reset", 8'h01);

        // Long increment run crossing the wrap
        drive(0, 1, 1, 8'h3C);
        edge_chk("load_3C", 8'h3C);
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) @(posedge clk);
        #2 check("run_wrap", int'(Dout), 8'h02);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
